// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the AXI-lite round-robin arbiter family.
//   arb_state_e  : transaction FSM states of axi_arbiter_rr
//   ARB_MAX_MST  : largest supported master count
// -----------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int ARB_MAX_MST = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the first asserted request at or
// after ptr, scanning upward and wrapping at N-1.
// Ports:
//   req     in  N     request vector
//   ptr     in  ID_W  index with highest priority this cycle
//   gnt_oh  out N     one-hot grant (all zero when no request)
//   gnt_id  out ID_W  encoded grant (0 when no request)
//   any_req out 1     at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt_oh,
    output logic [ID_W-1:0] gnt_id,
    output logic            any_req
);

    always_comb begin
        int idx;
        gnt_oh  = '0;
        gnt_id  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            // First hit in scan order wins; later hits are ignored.
            if (!any_req && req[ID_W'(idx)]) begin
                any_req             = 1'b1;
                gnt_oh[ID_W'(idx)]  = 1'b1;
                gnt_id              = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_arbiter_rr.sv
// -----------------------------------------------------------------------------
// axi_arbiter_rr
// N-master AXI-lite arbiter in front of a single AXI-lite slave. Masters are
// granted round-robin and keep the grant until their whole read (AR,R) or
// write (AW,W,B) transaction is done. One IDLE cycle separates transactions.
//
// Optional feature (compile-time macro ARB_HIPRIO_EN): master N_MST-1 wins
// arbitration in IDLE whenever it requests; rr_ptr still advances after it.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   s_AW_/s_AR_/s_W_*           per-master request channels ([N_MST-1:0] packed)
//   s_B_*, s_R_*                per-master response channels; s_R_DATA broadcast
//   m_*                         single slave-side AXI-lite port
//   grant_id                    granted master, meaningful while busy=1
//   busy                        a transaction is in flight
//   dbg_state, dbg_rr_ptr       FSM state and round-robin pointer for observation
//
// Handshake semantics: every channel transfers on a cycle where VALID and
// READY are both 1 at the rising edge of clk. VALID never depends on READY;
// the arbiter only forwards, so a forwarded VALID/READY is the granted
// master's or the slave's signal gated by the FSM state owning that channel.
// Outside the owning state all VALID/READY outputs of that channel are 0.
// -----------------------------------------------------------------------------
module axi_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    localparam int ID_W   = (N_MST > 1) ? $clog2(N_MST) : 1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // master side
    input  logic [N_MST-1:0][ADDR_W-1:0]  s_AW_ADDR,
    input  logic [N_MST-1:0]              s_AW_VALID,
    output logic [N_MST-1:0]              s_AW_READY,
    input  logic [N_MST-1:0][DATA_W-1:0]  s_W_DATA,
    input  logic [N_MST-1:0][STRB_W-1:0]  s_W_STRB,
    input  logic [N_MST-1:0]              s_W_VALID,
    output logic [N_MST-1:0]              s_W_READY,
    output logic [N_MST-1:0]              s_B_VALID,
    input  logic [N_MST-1:0]              s_B_READY,
    input  logic [N_MST-1:0][ADDR_W-1:0]  s_AR_ADDR,
    input  logic [N_MST-1:0]              s_AR_VALID,
    output logic [N_MST-1:0]              s_AR_READY,
    output logic [DATA_W-1:0]             s_R_DATA,
    output logic [N_MST-1:0]              s_R_VALID,
    input  logic [N_MST-1:0]              s_R_READY,
    // slave side
    output logic [ADDR_W-1:0]             m_AW_ADDR,
    output logic                          m_AW_VALID,
    input  logic                          m_AW_READY,
    output logic [DATA_W-1:0]             m_W_DATA,
    output logic [STRB_W-1:0]             m_W_STRB,
    output logic                          m_W_VALID,
    input  logic                          m_W_READY,
    input  logic                          m_B_VALID,
    output logic                          m_B_READY,
    output logic [ADDR_W-1:0]             m_AR_ADDR,
    output logic                          m_AR_VALID,
    input  logic                          m_AR_READY,
    input  logic [DATA_W-1:0]             m_R_DATA,
    input  logic                          m_R_VALID,
    output logic                          m_R_READY,
    // status / observation
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output arb_state_e                    dbg_state,
    output logic [ID_W-1:0]               dbg_rr_ptr
);

    if (N_MST < 1 || N_MST > ARB_MAX_MST) begin : g_bad_n_mst
        $error("axi_arbiter_rr: N_MST out of range");
    end

    arb_state_e       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_MST-1:0] req_vec;
    logic [N_MST-1:0] pick_oh;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic [ID_W-1:0]  win_id;
    logic             win_aw;
    logic [ID_W-1:0]  next_ptr;
    logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req_vec = s_AR_VALID | s_AW_VALID;

    rr_pick #(.N(N_MST), .ID_W(ID_W)) u_rr_pick (
        .req     (req_vec),
        .ptr     (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_id  (pick_id),
        .any_req (pick_any)
    );

`ifdef ARB_HIPRIO_EN
    // The last master (EXU data port) overrides the rotation when requesting.
    assign win_id = req_vec[N_MST-1] ? ID_W'(N_MST - 1) : pick_id;
    assign win_aw = req_vec[N_MST-1] ? s_AW_VALID[N_MST-1] : |(pick_oh & s_AW_VALID);
`else
    assign win_id = pick_id;
    assign win_aw = |(pick_oh & s_AW_VALID);
`endif

    assign next_ptr = (grant_id == ID_W'(N_MST - 1)) ? '0 : grant_id + ID_W'(1);

    assign ar_hs = m_AR_VALID & m_AR_READY;
    assign r_hs  = m_R_VALID  & m_R_READY;
    assign aw_hs = m_AW_VALID & m_AW_READY;
    assign w_hs  = m_W_VALID  & m_W_READY;
    assign b_hs  = m_B_VALID  & m_B_READY;

    // Transaction FSM; a pending write wins over a pending read of the same
    // master so a store is never overtaken by a later load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        state    <= win_aw ? WR_ADDR : RD_ADDR;
                    end
                end
                RD_ADDR: if (ar_hs) state <= RD_DATA;
                RD_DATA: begin
                    if (r_hs) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                WR_ADDR: if (aw_hs) state <= WR_DATA;
                WR_DATA: if (w_hs)  state <= WR_RESP;
                WR_RESP: begin
                    if (b_hs) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Payloads are muxed on the registered grant unconditionally; only the
    // VALID/READY qualifiers are gated by the state.
    assign m_AR_ADDR = s_AR_ADDR[grant_id];
    assign m_AW_ADDR = s_AW_ADDR[grant_id];
    assign m_W_DATA  = s_W_DATA[grant_id];
    assign m_W_STRB  = s_W_STRB[grant_id];
    assign s_R_DATA  = m_R_DATA;

    always_comb begin
        m_AR_VALID = 1'b0;
        m_AW_VALID = 1'b0;
        m_W_VALID  = 1'b0;
        m_R_READY  = 1'b0;
        m_B_READY  = 1'b0;
        s_AR_READY = '0;
        s_AW_READY = '0;
        s_W_READY  = '0;
        s_R_VALID  = '0;
        s_B_VALID  = '0;
        case (state)
            RD_ADDR: begin
                m_AR_VALID           = s_AR_VALID[grant_id];
                s_AR_READY[grant_id] = m_AR_READY;
            end
            RD_DATA: begin
                m_R_READY            = s_R_READY[grant_id];
                s_R_VALID[grant_id]  = m_R_VALID;
            end
            WR_ADDR: begin
                m_AW_VALID           = s_AW_VALID[grant_id];
                s_AW_READY[grant_id] = m_AW_READY;
            end
            WR_DATA: begin
                m_W_VALID            = s_W_VALID[grant_id];
                s_W_READY[grant_id]  = m_W_READY;
            end
            WR_RESP: begin
                m_B_READY            = s_B_READY[grant_id];
                s_B_VALID[grant_id]  = m_B_VALID;
            end
            default: ;
        endcase
    end

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_axi_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_rr
// Bench for axi_arbiter_rr with three masters. A transaction-level model
// (which master owns the slave, which kind of transaction, how many channel
// handshakes are done, next priority index) predicts every output each cycle.
// Directed sequences pin key behaviours with literal values, then a random
// phase exercises masters, slave and response readies. Honours ARB_HIPRIO_EN.
// -----------------------------------------------------------------------------
module tb_axi_arbiter_rr;
    import axi_arb_pkg::*;

    localparam int N    = 3;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;
    localparam int ID_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0][AW-1:0] ar_addr, aw_addr;
    logic [N-1:0][DW-1:0] w_data;
    logic [N-1:0][SW-1:0] w_strb;
    logic [N-1:0] ar_v, aw_v, w_v, r_rdy, b_rdy;
    logic [N-1:0] s_AR_READY, s_AW_READY, s_W_READY, s_R_VALID, s_B_VALID;
    logic [DW-1:0] s_R_DATA;
    logic [AW-1:0] m_AR_ADDR, m_AW_ADDR;
    logic [DW-1:0] m_W_DATA;
    logic [SW-1:0] m_W_STRB;
    logic m_AR_VALID, m_AW_VALID, m_W_VALID, m_R_READY, m_B_READY;
    logic sl_ar_rdy, sl_aw_rdy, sl_w_rdy, sl_r_v, sl_b_v;
    logic [DW-1:0] sl_r_data;
    logic [ID_W-1:0] grant_id, dbg_rr_ptr;
    logic busy;
    arb_state_e dbg_state;

    axi_arbiter_rr #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_AW_ADDR(aw_addr), .s_AW_VALID(aw_v), .s_AW_READY(s_AW_READY),
        .s_W_DATA(w_data), .s_W_STRB(w_strb), .s_W_VALID(w_v), .s_W_READY(s_W_READY),
        .s_B_VALID(s_B_VALID), .s_B_READY(b_rdy),
        .s_AR_ADDR(ar_addr), .s_AR_VALID(ar_v), .s_AR_READY(s_AR_READY),
        .s_R_DATA(s_R_DATA), .s_R_VALID(s_R_VALID), .s_R_READY(r_rdy),
        .m_AW_ADDR(m_AW_ADDR), .m_AW_VALID(m_AW_VALID), .m_AW_READY(sl_aw_rdy),
        .m_W_DATA(m_W_DATA), .m_W_STRB(m_W_STRB), .m_W_VALID(m_W_VALID), .m_W_READY(sl_w_rdy),
        .m_B_VALID(sl_b_v), .m_B_READY(m_B_READY),
        .m_AR_ADDR(m_AR_ADDR), .m_AR_VALID(m_AR_VALID), .m_AR_READY(sl_ar_rdy),
        .m_R_DATA(sl_r_data), .m_R_VALID(sl_r_v), .m_R_READY(m_R_READY),
        .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;
    bit rand_mode = 1'b0;
    logic [N-1:0] auto_rd = '0;
    logic [7:0] grant_log_q[$];
    logic [7:0] gap_q[$];
    logic [7:0] exp_q[$];
    int  idle_run = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner valid, owner index, kind (0 read / 1 write), handshakes done, next priority
    bit mb = 1'b0;
    int mg = 0;
    int mk = 0;
    int ms = 0;
    int mp = 0;

    always @(negedge clk) begin
        int ch;
        int w;
        bit hs;
        logic [N-1:0] oh, z, req;
        arb_state_e est;
        if (started) begin
            // channel owning the slave: 0 none, 1 AR, 2 R, 3 AW, 4 W, 5 B
            ch = 0;
            if (mb) ch = (mk == 0) ? 1 + ms : 3 + ms;
            z = '0;
            oh = '0;
            oh[mg] = 1'b1;
            case (ch)
                1: est = RD_ADDR;
                2: est = RD_DATA;
                3: est = WR_ADDR;
                4: est = WR_DATA;
                5: est = WR_RESP;
                default: est = IDLE;
            endcase
            chk("state", dbg_state, est);
            chk("busy", busy, mb);
            chk("rr_ptr", dbg_rr_ptr, mp);
            if (mb) chk("grant_id", grant_id, mg);
            chk("m_valids", {m_AR_VALID, m_AW_VALID, m_W_VALID},
                {(ch == 1) && ar_v[mg], (ch == 3) && aw_v[mg], (ch == 4) && w_v[mg]});
            chk("s_readies", {s_AR_READY, s_AW_READY, s_W_READY},
                {(ch == 1 && sl_ar_rdy) ? oh : z, (ch == 3 && sl_aw_rdy) ? oh : z,
                 (ch == 4 && sl_w_rdy) ? oh : z});
            chk("s_valids", {s_R_VALID, s_B_VALID},
                {(ch == 2 && sl_r_v) ? oh : z, (ch == 5 && sl_b_v) ? oh : z});
            chk("m_readies", {m_R_READY, m_B_READY}, {(ch == 2) && r_rdy[mg], (ch == 5) && b_rdy[mg]});
            if (ch == 1) chk("m_AR_ADDR", m_AR_ADDR, ar_addr[mg]);
            if (ch == 3) chk("m_AW_ADDR", m_AW_ADDR, aw_addr[mg]);
            if (ch == 4) chk("m_W_DATA", m_W_DATA, w_data[mg]);
            if (ch == 4) chk("m_W_STRB", m_W_STRB, w_strb[mg]);
            chk("s_R_DATA", s_R_DATA, sl_r_data);

            // grant / idle-gap log taken from the DUT for directed checks
            if (busy && !prev_busy) begin
                if (grant_log_q.size() > 0) gap_q.push_back(8'(idle_run));
                grant_log_q.push_back(8'(grant_id));
            end
            if (busy) idle_run = 0;
            else idle_run++;
            prev_busy = busy;

            // advance model to the state after the coming edge
            if (!rst_n) begin
                mb = 1'b0; mg = 0; mk = 0; ms = 0; mp = 0;
            end else if (!mb) begin
                req = ar_v | aw_v;
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(mp + k) % N]) w = (mp + k) % N;
`ifdef ARB_HIPRIO_EN
                if (req[N-1]) w = N - 1;
`endif
                if (w >= 0) begin
                    mb = 1'b1; mg = w; mk = aw_v[w] ? 1 : 0; ms = 0;
                end
            end else begin
                case (ch)
                    1: hs = ar_v[mg] && sl_ar_rdy;
                    2: hs = sl_r_v && r_rdy[mg];
                    3: hs = aw_v[mg] && sl_aw_rdy;
                    4: hs = w_v[mg] && sl_w_rdy;
                    default: hs = sl_b_v && b_rdy[mg];
                endcase
                if (hs) begin
                    if (ch == 2 || ch == 5) begin
                        mb = 1'b0;
                        mp = (mg + 1) % N;
                    end else begin
                        ms++;
                    end
                end
            end
        end
    end

    // ---------------- master / slave driver ----------------
    logic [N-1:0] ar_hs, aw_hs, w_hs;
    initial begin
        forever begin
            @(negedge clk);
            ar_hs = ar_v & s_AR_READY;
            aw_hs = aw_v & s_AW_READY;
            w_hs  = w_v & s_W_READY;
            @(posedge clk);
            #1;
            ar_v = ar_v & ~ar_hs;
            aw_v = aw_v & ~aw_hs;
            w_v  = w_v & ~w_hs;
            for (int i = 0; i < N; i++) begin
                if (auto_rd[i] && !ar_v[i]) begin
                    ar_v[i] = 1'b1;
                    ar_addr[i] = {$urandom, $urandom};
                end
                if (rand_mode && !ar_v[i] && !aw_v[i] && !w_v[i]) begin
                    case ($urandom_range(0, 7))
                        0: begin ar_v[i] = 1'b1; ar_addr[i] = {$urandom, $urandom}; end
                        1, 2: begin
                            aw_v[i] = 1'b1; w_v[i] = 1'b1;
                            aw_addr[i] = {$urandom, $urandom};
                            w_data[i] = {$urandom, $urandom};
                            w_strb[i] = 8'($urandom_range(0, 255));
                            ar_v[i] = ($urandom_range(0, 1) == 1);
                            ar_addr[i] = {$urandom, $urandom};
                        end
                        default: ;
                    endcase
                end
            end
            if (rand_mode) begin
                sl_ar_rdy = 1'($urandom_range(0, 1));
                sl_aw_rdy = 1'($urandom_range(0, 1));
                sl_w_rdy  = 1'($urandom_range(0, 1));
                sl_r_v    = 1'($urandom_range(0, 1));
                sl_b_v    = 1'($urandom_range(0, 1));
                sl_r_data = {$urandom, $urandom};
                r_rdy     = N'($urandom_range(0, 7));
                b_rdy     = N'($urandom_range(0, 7));
            end
        end
    end

    task automatic all_ready();
        sl_ar_rdy = 1'b1; sl_aw_rdy = 1'b1; sl_w_rdy = 1'b1;
        sl_r_v = 1'b1; sl_b_v = 1'b1;
        r_rdy = '1; b_rdy = '1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        ar_v = '0; aw_v = '0; w_v = '0; auto_rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log_q.delete();
        gap_q.delete();
    endtask

    // Let every outstanding request finish with a fully ready slave.
    task automatic drain();
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        all_ready();
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && ar_v == '0 && aw_v == '0 && w_v == '0) done = 1'b1;
        end
        chk("drain_timeout", done, 1'b1);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    endtask

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
    end

    // ---------------- directed + random sequences ----------------
    initial begin
        bit ok;
        ar_v = '0; aw_v = '0; w_v = '0; r_rdy = '0; b_rdy = '0;
        ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
        sl_ar_rdy = 1'b0; sl_aw_rdy = 1'b0; sl_w_rdy = 1'b0;
        sl_r_v = 1'b0; sl_b_v = 1'b0; sl_r_data = '0;
        @(posedge clk); #1;
        started = 1'b1;

        // reset values
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_ptr", dbg_rr_ptr, 2'd0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_vr", {m_AR_VALID, m_AW_VALID, m_W_VALID, m_R_READY, m_B_READY,
                       s_AR_READY, s_AW_READY, s_W_READY, s_R_VALID, s_B_VALID}, 0);

        // single read by master 0
        do_reset();
        all_ready();
        sl_r_data = 64'hDEAD_BEEF;
        ar_addr[0] = 64'h8000_0000;
        ar_v[0] = 1'b1;
        @(negedge clk);
        chk("rd_idle_busy", busy, 1'b0);
        @(negedge clk);
        chk("rd_m_ar_valid", m_AR_VALID, 1'b1);
        chk("rd_m_ar_addr", m_AR_ADDR, 64'h8000_0000);
        @(negedge clk);
        chk("rd_s_r_valid", s_R_VALID, 3'b001);
        chk("rd_s_r_data", s_R_DATA, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_done_busy", busy, 1'b0);
        chk("rd_done_ptr", dbg_rr_ptr, 2'd1);

        // two masters reading back to back alternate with one idle cycle
        do_reset();
        all_ready();
        auto_rd = 3'b011;
        ar_v = 3'b011;
        for (int i = 0; i < 200 && grant_log_q.size() < 4; i++) @(negedge clk);
        auto_rd = '0;
        exp_q = '{8'd0, 8'd1, 8'd0, 8'd1};
        for (int i = 0; i < 4; i++)
            chk("rr_grant_order", (i < grant_log_q.size()) ? grant_log_q[i] : 8'hff, exp_q[i]);
        for (int i = 0; i < 3; i++)
            chk("rr_idle_gap", (i < gap_q.size()) ? gap_q[i] : 8'hff, 8'd1);
        drain();

        // write before read for the same master
        do_reset();
        all_ready();
        aw_addr[1] = 64'h8000_0010; w_data[1] = 64'h1234; w_strb[1] = 8'h0F;
        ar_addr[1] = 64'h8000_0020;
        aw_v[1] = 1'b1; w_v[1] = 1'b1; ar_v[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_m_aw_valid", {m_AW_VALID, m_AR_VALID}, 2'b10);
        chk("wr_m_aw_addr", m_AW_ADDR, 64'h8000_0010);
        @(negedge clk);
        chk("wr_m_w", {m_W_VALID, m_W_STRB, m_W_DATA[15:0]}, {1'b1, 8'h0F, 16'h1234});
        @(negedge clk);
        chk("wr_s_b_valid", s_B_VALID, 3'b010);
        @(negedge clk);
        chk("wr_gap_busy", busy, 1'b0);
        @(negedge clk);
        chk("wr_then_rd", {m_AR_VALID, 6'(grant_id)}, {1'b1, 6'd1});
        chk("wr_then_rd_addr", m_AR_ADDR, 64'h8000_0020);
        drain();

        // slave stalls R, then master stalls R_READY; no other grant meanwhile
        do_reset();
        all_ready();
        sl_r_v = 1'b0;
        r_rdy = 3'b110;
        ar_addr[0] = 64'h100; ar_addr[1] = 64'h200;
        ar_v = 3'b011;
        @(negedge clk);
        @(negedge clk);
        chk("stall_grant", grant_id, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rvalid_low", {dbg_state, s_R_VALID}, {RD_DATA, 3'b000});
        end
        @(posedge clk); #1;
        sl_r_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rready_low", {dbg_state, s_R_VALID, m_R_READY, grant_id},
                {RD_DATA, 3'b001, 1'b0, 2'd0});
        end
        @(posedge clk); #1;
        r_rdy = 3'b111;
        @(negedge clk);
        chk("stall_release", m_R_READY, 1'b1);
        @(negedge clk);
        chk("stall_idle", busy, 1'b0);
        @(negedge clk);
        chk("stall_next_grant", {m_AR_VALID, grant_id}, {1'b1, 2'd1});
        drain();

        // reset during WR_DATA
        do_reset();
        all_ready();
        ar_addr[0] = 64'h40;
        ar_v[0] = 1'b1;
        drain();
        sl_w_rdy = 1'b0;
        aw_addr[1] = 64'h80; w_data[1] = 64'h55; w_strb[1] = 8'hFF;
        aw_v[1] = 1'b1; w_v[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wrst_pre_state", {dbg_state, grant_id, dbg_rr_ptr}, {WR_DATA, 2'd1, 2'd1});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrst_state", {dbg_state, busy, grant_id, dbg_rr_ptr}, {IDLE, 1'b0, 2'd0, 2'd0});
        chk("wrst_vr", {m_AR_VALID, m_AW_VALID, m_W_VALID, m_R_READY, m_B_READY,
                        s_AR_READY, s_AW_READY, s_W_READY, s_R_VALID, s_B_VALID}, 0);
        @(posedge clk); #1;
        ar_v = '0; aw_v = '0; w_v = '0;
        rst_n = 1'b1;

        // three simultaneous requesters from rr_ptr=0
        do_reset();
        all_ready();
        ar_v = 3'b111;
        @(negedge clk);
        @(negedge clk);
`ifdef ARB_HIPRIO_EN
        chk("first_grant_3req", grant_id, 2'd2);
`else
        chk("first_grant_3req", grant_id, 2'd0);
`endif
        drain();

        // random traffic
        do_reset();
        rand_mode = 1'b1;
        repeat (4000) @(posedge clk);
        #1;
        rand_mode = 1'b0;
        drain();
        ok = (grant_log_q.size() > 50);
        chk("rand_activity", ok, 1'b1);

        summary();
    end

endmodule
